// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Owner encoding plus default starvation and burst limits.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned MAX_BURST_DEF  = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at MAX.
module arb_sat_counter #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the DMEM port between the memory stage and a DMA loader.
// CPU owns by default; DMA takes idle or starved slots, one burst per grant.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [DW/8-1:0] cpu_wmask,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_stall,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [DW/8-1:0] dma_wmask,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  input  logic            dma_last,
  output logic            dma_gnt,
  output logic [DW-1:0]   dma_rdata,
  output logic            dma_rvalid,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wmask,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  owner_e        r_state;
  owner_e        w_next;
  logic [SW-1:0] w_starve;
  logic [BW-1:0] w_beat;
  logic          w_own_dma;
  logic          w_take;
  logic          w_release;
  logic          w_starve_inc;
  logic          w_starve_clr;
  logic          w_beat_acc;
  logic [DW-1:0] r_dma_rdata;
  logic          r_dma_rvalid;

  assign w_own_dma = (r_state == OWN_DMA);
  assign w_beat_acc = w_own_dma & dma_req;

  assign w_take = ~w_own_dma & dma_req &
    (~cpu_req | (w_starve == SW'(STARVE_MAX - 1)));

  assign w_release = w_own_dma &
    (~dma_req | dma_last | (w_beat == BW'(MAX_BURST - 1)));

  // Starvation only accrues while the CPU holds the port against the DMA
  assign w_starve_inc = ~w_own_dma & dma_req & cpu_req;
  assign w_starve_clr = ~dma_req | w_own_dma;

  arb_sat_counter #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve)
  );

  arb_sat_counter #(
    .MAX (MAX_BURST),
    .W   (BW)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_beat_acc),
    .i_clr (w_release),
    .o_cnt (w_beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= OWN_CPU;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      OWN_CPU: if (w_take) w_next = OWN_DMA;
      OWN_DMA: if (w_release) w_next = OWN_CPU;
    endcase
  end

  always_comb begin
    mem_we    = cpu_req & cpu_we;
    mem_wmask = cpu_wmask;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    unique case (1'b1)
      w_own_dma: begin
        mem_we    = dma_req & dma_we;
        mem_wmask = dma_wmask;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_gnt   = dma_req;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_rdata  <= mem_rdata;
      r_dma_rvalid <= dma_gnt & ~dma_we;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a DMA read-data scoreboard.
// Each step states the expected owner; port behaviour follows from it.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [3:0]  dma_wmask;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          total;
  int          bad;
  logic        exp_rv;
  logic [31:0] sb[$];

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign mem_rdata = mdat(mem_addr);

  dmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_wmask  (cpu_wmask),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_wmask  (dma_wmask),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_last   (dma_last),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_we     (mem_we),
    .mem_wmask  (mem_wmask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkcyc(input logic own);
    logic [31:0] a;
    a = own ? dma_addr : cpu_addr;
    chk("gnt", dma_gnt, own & dma_req);
    chk("stall", cpu_stall, own & cpu_req);
    chk("mem_addr", mem_addr, a);
    chk("mem_wr", {mem_we, mem_wmask, mem_wdata},
        own ? {dma_req & dma_we, dma_wmask, dma_wdata}
            : {cpu_req & cpu_we, cpu_wmask, cpu_wdata});
    chk("cpu_rdata", cpu_rdata, mdat(a));
    chk("rvalid", dma_rvalid, exp_rv);
    if (exp_rv) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("dma_rdata", dma_rdata, sb.pop_front());
    end
    exp_rv = own & dma_req & ~dma_we;
    if (exp_rv) sb.push_back(mdat(dma_addr));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic own);
    #2;
    chkcyc(own);
    adv();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_rv = 1'b0;
    rst = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_wmask = 4'h0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_wmask = 4'hF;
    dma_addr = 32'h0;
    dma_wdata = 32'h0;
    dma_last = 1'b0;

    // reset state, with a DMA request pending
    adv();
    #2;
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_rdata", dma_rdata, 0);
    adv();
    rst = 1'b1;
    dma_req = 1'b0;

    // 1: CPU only
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 32'h10;
    cpu_wmask = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      cpu_wdata = 32'hC0DE_0000 + i;
      cyc(1'b0);
    end

    // 2: CPU idle, 4-beat DMA write
    cpu_req = 1'b0;
    dma_req = 1'b1;
    dma_we = 1'b1;
    dma_addr = 32'h100;
    dma_wdata = 32'hD000_0000;
    cyc(1'b0);
    for (int i = 0; i < 4; i++) begin
      dma_addr = 32'h100 + 4 * i;
      dma_wdata = 32'hD000_0000 + i;
      dma_wmask = 4'hF ^ 4'(i);
      dma_last = (i == 3);
      cyc(1'b1);
    end
    dma_req = 1'b0;
    dma_last = 1'b0;
    cyc(1'b0);

    // 3: starvation handover with both sides requesting
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h20;
    dma_req = 1'b1;
    dma_addr = 32'h200;
    dma_last = 1'b1;
    repeat (8) cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    dma_req = 1'b0;
    cyc(1'b0);

    // 4: 20-beat read burst, no last, split by MAX_BURST
    cpu_req = 1'b0;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_last = 1'b0;
    begin
      int b;
      b = 0;
      dma_addr = 32'h400;
      cyc(1'b0);
      repeat (16) begin
        dma_addr = 32'h400 + 4 * b;
        cyc(1'b1);
        b++;
      end
      dma_addr = 32'h400 + 4 * b;
      cyc(1'b0);
      repeat (4) begin
        dma_addr = 32'h400 + 4 * b;
        cyc(1'b1);
        b++;
      end
    end
    dma_req = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    chk("sb_empty", sb.size(), 0);

    // 5: asynchronous reset at beat 3 of a burst
    cpu_we = 1'b1;
    dma_req = 1'b1;
    dma_addr = 32'h600;
    cyc(1'b0);
    cyc(1'b1);
    dma_addr = 32'h604;
    cyc(1'b1);
    dma_addr = 32'h608;
    dma_we = 1'b1;
    dma_wdata = 32'h0BAD_F00D;
    #2;
    chkcyc(1'b1);
    rst = 1'b0;
    #1;
    chk("arst_gnt", dma_gnt, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_rvalid", dma_rvalid, 0);
    chk("arst_addr", mem_addr, cpu_addr);
    exp_rv = 1'b0;
    sb.delete();
    adv();
    adv();
    #2;
    chk("arst_hold_gnt", dma_gnt, 0);
    #1;
    rst = 1'b1;
    dma_req = 1'b0;
    adv();
    cyc(1'b0);

    // 6: DMA drops its request mid-burst while the CPU waits
    dma_req = 1'b1;
    dma_addr = 32'h800;
    cyc(1'b0);
    cpu_req = 1'b1;
    cyc(1'b1);
    dma_addr = 32'h804;
    cyc(1'b1);
    dma_req = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
